// File: rtl/apb_irq_event_ctrl.sv
// rtl/apb_irq_event_ctrl.sv - APB interrupt/event controller with sleep FSM and core clock gating
// Optional macro EVENT_INPUT_SYNC_EN: adds a 2-flop synchroniser on every irq_i bit.
module apb_irq_event_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 32,
  parameter int WAKE_DELAY     = 4
) (
  input  logic                      clk_i,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        irq_i,
  output logic [NUM_SRC-1:0]        irq_o,
  input  logic                      fetch_enable_i,
  output logic                      fetch_enable_o,
  output logic                      clk_gate_core_o,
  input  logic                      core_busy_i
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_SLEEP     = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_DELAY - 1);

  state_t               state_q, state_d;
  logic [7:0]           wake_cnt_q, wake_cnt_d;
  logic [NUM_SRC-1:0]   ier, ipr, edge_sel, irq_prev;
  logic [NUM_SRC-1:0]   irq_src, hw_set, ipr_next, wdata_src;
  logic [2:0]           reg_idx;
  logic                 addr_err, wr_en;
  logic                 wr_ier, wr_iset, wr_iclr, wr_edge, wr_sleep;
  logic                 fe_meta, fe_s;
  logic                 any_irq;
  logic [4:0]           id_idx;
  logic [31:0]          rdata;
  logic                 unused_bits;

  assign reg_idx   = PADDR[4:2];
  assign addr_err  = (PADDR[APB_ADDR_WIDTH-1:5] != '0);
  assign wr_en     = PSEL & PENABLE & PWRITE & ~addr_err;
  assign wdata_src = PWDATA[NUM_SRC-1:0];
  assign wr_ier    = wr_en & (reg_idx == 3'd0);
  assign wr_iset   = wr_en & (reg_idx == 3'd2);
  assign wr_iclr   = wr_en & (reg_idx == 3'd3);
  assign wr_edge   = wr_en & (reg_idx == 3'd4);
  assign wr_sleep  = wr_en & (reg_idx == 3'd6);

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & addr_err;

  // Address bits [1:0] and write-data bits above NUM_SRC carry no meaning here.
  assign unused_bits = ^{PADDR[1:0], PWDATA};

`ifdef EVENT_INPUT_SYNC_EN
  logic [NUM_SRC-1:0] irq_meta, irq_sync;

  // Two-flop synchroniser for sources asynchronous to clk_i.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= irq_i;
      irq_sync <= irq_meta;
    end
  end

  assign irq_src = irq_sync;
`else
  assign irq_src = irq_i;
`endif

  // Edge sources fire only on a 0->1 transition of the sample; level sources fire while high.
  assign hw_set   = (~edge_sel & irq_src) | (edge_sel & irq_src & ~irq_prev);
  // Hardware set and ISET both win over ICLR in the same cycle.
  assign ipr_next = (ipr & ~(wr_iclr ? wdata_src : '0)) | hw_set | (wr_iset ? wdata_src : '0);

  assign irq_o   = ipr & ier;
  assign any_irq = |irq_o;

  // Configuration, pending state and the previous-cycle input sample.
  // The sample tracks the input every cycle, so an EDGE change never sees a stale value.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      ier      <= '0;
      ipr      <= '0;
      edge_sel <= '0;
      irq_prev <= '0;
    end else begin
      ipr      <= ipr_next;
      irq_prev <= irq_src;
      if (wr_ier)  ier      <= wdata_src;
      if (wr_edge) edge_sel <= wdata_src;
    end
  end

  // Fetch-enable pad synchroniser.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      fe_meta <= 1'b0;
      fe_s    <= 1'b0;
    end else begin
      fe_meta <= fetch_enable_i;
      fe_s    <= fe_meta;
    end
  end

  // Sleep FSM state and wake counter registers.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_RUN;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  // Sleep FSM next-state: sleep request only honoured from RUN, wake holds fetch for WAKE_DELAY cycles.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (wr_sleep && PWDATA[0]) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (any_irq)           state_d = ST_RUN;
        else if (!core_busy_i) state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (any_irq) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == 8'd0) state_d = ST_RUN;
        else                    wake_cnt_d = wake_cnt_q - 8'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign clk_gate_core_o = (state_q != ST_SLEEP);
  assign fetch_enable_o  = fe_s & (state_q == ST_RUN);

  // Priority encoder: lowest pending-and-enabled index wins.
  always_comb begin
    id_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (irq_o[i]) id_idx = 5'(i);
    end
  end

  // Combinational read mux; unmapped addresses and write-only registers read 0.
  always_comb begin
    rdata = '0;
    case (reg_idx)
      3'd0:    rdata = 32'(ier);
      3'd1:    rdata = 32'(ipr);
      3'd4:    rdata = 32'(edge_sel);
      3'd5:    rdata = {any_irq, 26'd0, id_idx};
      3'd7:    rdata = {23'd0, fetch_enable_o, 6'd0, state_q};
      default: rdata = '0;
    endcase
    if (addr_err) rdata = '0;
  end

  assign PRDATA = rdata;

endmodule

// File: tb/tb_apb_irq_event_ctrl.sv
// tb/tb_apb_irq_event_ctrl.sv - self-checking bench for apb_irq_event_ctrl
module tb_apb_irq_event_ctrl;

  logic        clk_i = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  irq_i, irq_o;
  logic        fetch_enable_i, fetch_enable_o, clk_gate_core_o, core_busy_i;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  apb_irq_event_ctrl #(.APB_ADDR_WIDTH(12), .NUM_SRC(8), .WAKE_DELAY(4)) dut (
    .clk_i(clk_i), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq_i(irq_i), .irq_o(irq_o), .fetch_enable_i(fetch_enable_i), .fetch_enable_o(fetch_enable_o),
    .clk_gate_core_o(clk_gate_core_o), .core_busy_i(core_busy_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    @(negedge clk_i);
    data = PRDATA;
    err  = PSLVERR;
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Scoreboarded read: expectation queued at stimulus time, popped when read data returns.
  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp, input logic exp_err);
    logic [31:0] d;
    logic        e;
    exp_q.push_back(exp);
    apb_read(addr, d, e);
    check_val({tag, "_err"}, 32'(e), 32'(exp_err));
    check_val(tag, d, exp_q.pop_front());
  endtask

  initial begin
    int n;
    logic seen;
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    irq_i = '0; fetch_enable_i = 1'b0; core_busy_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_gate", 32'(clk_gate_core_o), 32'd1);
    check_val("rst_irq_o", 32'(irq_o), 32'd0);
    check_val("rst_fetch", 32'(fetch_enable_o), 32'd0);
    check_val("rst_prdata", PRDATA, 32'd0);
    #2 HRESETn = 1'b1;

    for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_reg%0d", i), 12'(i * 4), 32'd0, 1'b0);

    apb_write(12'h000, 32'hFFFF_FFFF);
    rd_chk("ier_width", 12'h000, 32'h0000_00FF, 1'b0);

    // Edge bit0 pulse, level bit1 held
    apb_write(12'h010, 32'h1);
    apb_write(12'h000, 32'h3);
    @(posedge clk_i); #1 irq_i = 8'h03;
    @(posedge clk_i); #1 irq_i = 8'h02;
    rd_chk("ipr_both", 12'h004, 32'h3, 1'b0);
    @(negedge clk_i);
    check_val("irq_o_both", 32'(irq_o), 32'h3);
    rd_chk("id_both", 12'h014, 32'h8000_0000, 1'b0);
    apb_write(12'h00C, 32'h3);
    rd_chk("ipr_lvl_stays", 12'h004, 32'h2, 1'b0);
    irq_i = 8'h00;
    apb_write(12'h00C, 32'h2);
    rd_chk("ipr_cleared", 12'h004, 32'h0, 1'b0);

    // Software set with mask
    apb_write(12'h000, 32'h0);
    apb_write(12'h008, 32'h10);
    rd_chk("ipr_iset", 12'h004, 32'h10, 1'b0);
    @(negedge clk_i);
    check_val("irq_o_masked", 32'(irq_o), 32'h0);
    rd_chk("id_masked", 12'h014, 32'h0, 1'b0);
    apb_write(12'h000, 32'h10);
    rd_chk("id_src4", 12'h014, 32'h8000_0004, 1'b0);
    apb_write(12'h00C, 32'h10);

    // Hardware edge on bit2 in the same cycle as ICLR bit2
    apb_write(12'h010, 32'h4);
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C; PWDATA = 32'h4;
    @(posedge clk_i); #1;
    PENABLE = 1'b1; irq_i = 8'h04;
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rd_chk("set_beats_clr", 12'h004, 32'h4, 1'b0);
    apb_write(12'h00C, 32'h4);
    rd_chk("edge_held_clr", 12'h004, 32'h0, 1'b0);
    irq_i = 8'h00;

    // Sleep / wake sequence
    fetch_enable_i = 1'b1;
    apb_write(12'h000, 32'h1);
    @(negedge clk_i);
    check_val("fetch_run", 32'(fetch_enable_o), 32'd1);
    core_busy_i = 1'b1;
    apb_write(12'h018, 32'h1);
    rd_chk("st_wait_idle", 12'h01C, 32'h1, 1'b0);
    repeat (5) @(posedge clk_i);
    #1 core_busy_i = 1'b0;
    rd_chk("st_sleep", 12'h01C, 32'h2, 1'b0);
    @(negedge clk_i);
    check_val("sleep_gate", 32'(clk_gate_core_o), 32'd0);
    check_val("sleep_fetch", 32'(fetch_enable_o), 32'd0);
    @(posedge clk_i); #1 irq_i = 8'h01;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (clk_gate_core_o) seen = 1'b1;
    end
    check_val("wake_gate", 32'(seen), 32'd1);
    n = 0;
    while (!fetch_enable_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_val("wake_delay", 32'(n), 32'd4);
    irq_i = 8'h00;
    apb_write(12'h00C, 32'h1);
    rd_chk("st_run_fe", 12'h01C, 32'h100, 1'b0);

    // Unmapped accesses
    rd_chk("bad_addr_rd", 12'h020, 32'h0, 1'b1);
    apb_write(12'h020, 32'h0);
    rd_chk("bad_wr_ier", 12'h000, 32'h1, 1'b0);
    apb_write(12'h038, 32'h1);
    rd_chk("bad_wr_sleep", 12'h01C, 32'h100, 1'b0);

    // Reset while sleeping
    apb_write(12'h018, 32'h1);
    repeat (2) @(posedge clk_i);
    #1;
    check_val("pre_rst_gate", 32'(clk_gate_core_o), 32'd0);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h01C;
    #1 HRESETn = 1'b0;
    #1;
    check_val("rst_sleep_gate", 32'(clk_gate_core_o), 32'd1);
    check_val("rst_sleep_status", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk_i); #2 HRESETn = 1'b1;
    rd_chk("post_rst_ier", 12'h000, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
